// File: rtl/pdp8_mem_seq_pkg.sv
// Shared widths, state encoding and default strobe timing for the PDP-8 memory sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pdp8_mem_pkg;

    localparam int PDP8_ADDR_W = 15;   // field[2:0] + page/word[11:0]
    localparam int PDP8_DATA_W = 12;

    // Default SRAM strobe timing, in core clock cycles
    localparam int DEF_RD_CYCLES = 2;
    localparam int DEF_WR_SETUP  = 1;
    localparam int DEF_WR_PULSE  = 2;
    localparam int DEF_WR_HOLD   = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SU,
        WR_PW,
        WR_HD
    } mem_seq_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // The counter holds (cycles - 1), so it needs to reach max_cycles - 1
    function automatic int cnt_width(input int max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/pdp8_mem_seq_if.sv
// CPU-side request bus and SRAM-side strobe bus of the PDP-8 memory sequencer.
// Latency: n/a (wiring only).
// Backpressure: busy on the CPU bus; requests seen while busy are dropped.
interface pdp8_cpu_mem_if;
    import pdp8_mem_pkg::*;

    logic                   req;
    logic                   we;
    logic [PDP8_ADDR_W-1:0] addr;
    logic [PDP8_DATA_W-1:0] wdata;
    logic [PDP8_DATA_W-1:0] rdata;
    logic                   ack;
    logic                   busy;

    // master = CPU major-state logic, slave = memory sequencer
    modport master (output req, we, addr, wdata, input  rdata, ack, busy);
    modport slave  (input  req, we, addr, wdata, output rdata, ack, busy);
endinterface

interface pdp8_sram_if;
    import pdp8_mem_pkg::*;

    logic [PDP8_ADDR_W-1:0] ram_addr;
    logic [PDP8_DATA_W-1:0] ram_data_in;
    logic [PDP8_DATA_W-1:0] ram_data_out;
    logic                   ram_rd;
    logic                   ram_wr;

    // master = memory sequencer, slave = asynchronous SRAM
    modport master (output ram_addr, ram_data_in, ram_rd, ram_wr, input  ram_data_out);
    modport slave  (input  ram_addr, ram_data_in, ram_rd, ram_wr, output ram_data_out);
endinterface

// File: rtl/pdp8_mem_seq.sv
// Sequences single-word reads/writes onto the 32Kx12 async SRAM with programmable setup/pulse/hold.
// Latency: read ack RD_CYCLES edges after accept; write ack WR_SETUP+WR_PULSE+WR_HOLD edges after accept.
// Backpressure: busy=1 during a transfer; req is ignored (not queued) while busy, new req accepted in the ack cycle.
module pdp8_mem_seq
    import pdp8_mem_pkg::*;
#(
    parameter int RD_CYCLES = DEF_RD_CYCLES,
    parameter int WR_SETUP  = DEF_WR_SETUP,
    parameter int WR_PULSE  = DEF_WR_PULSE,
    parameter int WR_HOLD   = DEF_WR_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    pdp8_cpu_mem_if.slave    cpu,
    pdp8_sram_if.master      ram
);

    localparam int CNT_W = cnt_width(max4(RD_CYCLES, WR_SETUP, WR_PULSE, WR_HOLD));

    // Reload values: each phase counts down to zero, so load cycles-1
    localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SU_LD = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] PW_LD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] HD_LD = CNT_W'(WR_HOLD - 1);

    // A zero-length phase would collapse the strobe timing, so refuse to elaborate
    if (RD_CYCLES < 1 || WR_SETUP < 1 || WR_PULSE < 1 || WR_HOLD < 1) begin : g_bad_timing
        $error("pdp8_mem_seq: RD_CYCLES, WR_SETUP, WR_PULSE and WR_HOLD must all be >= 1");
    end

    mem_seq_state_t         state,     state_nxt;
    logic [CNT_W-1:0]       cnt,       cnt_nxt;
    logic                   ack_q,     ack_nxt;
    logic                   busy_q,    busy_nxt;
    logic                   rd_q,      rd_nxt;
    logic                   wr_q,      wr_nxt;
    logic [PDP8_DATA_W-1:0] rdata_q,   rdata_nxt;
    logic [PDP8_ADDR_W-1:0] addr_q,    addr_nxt;
    logic [PDP8_DATA_W-1:0] din_q,     din_nxt;

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        busy_nxt  = busy_q;
        rd_nxt    = rd_q;
        wr_nxt    = wr_q;
        rdata_nxt = rdata_q;
        addr_nxt  = addr_q;
        din_nxt   = din_q;

        unique case (state)
            IDLE: begin
                if (cpu.req) begin
                    addr_nxt = cpu.addr;
                    busy_nxt = 1'b1;
                    if (cpu.we) begin
                        din_nxt   = cpu.wdata;
                        cnt_nxt   = SU_LD;
                        state_nxt = WR_SU;
                    end else begin
                        // Output enable goes up together with the address
                        rd_nxt    = 1'b1;
                        cnt_nxt   = RD_LD;
                        state_nxt = RD;
                    end
                end
            end

            RD: begin
                if (cnt == '0) begin
                    // Sample while ram_rd is still high, then drop it
                    rdata_nxt = ram.ram_data_out;
                    rd_nxt    = 1'b0;
                    ack_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            WR_SU: begin
                if (cnt == '0) begin
                    wr_nxt    = 1'b1;
                    cnt_nxt   = PW_LD;
                    state_nxt = WR_PW;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            WR_PW: begin
                if (cnt == '0) begin
                    wr_nxt    = 1'b0;
                    cnt_nxt   = HD_LD;
                    state_nxt = WR_HD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            WR_HD: begin
                if (cnt == '0) begin
                    ack_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            default: begin
                rd_nxt    = 1'b0;
                wr_nxt    = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset drops strobes at once and issues no ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ack_q   <= ack_nxt;
            busy_q  <= busy_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            rdata_q <= rdata_nxt;
            addr_q  <= addr_nxt;
            din_q   <= din_nxt;
        end
    end

    assign cpu.rdata       = rdata_q;
    assign cpu.ack         = ack_q;
    assign cpu.busy        = busy_q;
    assign ram.ram_addr    = addr_q;
    assign ram.ram_data_in = din_q;
    assign ram.ram_rd      = rd_q;
    assign ram.ram_wr      = wr_q;

endmodule

// File: tb/tb_pdp8_mem_seq.sv
// Directed table plus corner sequences against default timing, random mix against all-1 timing.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_pdp8_mem_seq;
    import pdp8_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pdp8_cpu_mem_if cpu0();
    pdp8_sram_if    ram0();
    pdp8_cpu_mem_if cpu1();
    pdp8_sram_if    ram1();

    pdp8_mem_seq u_dut_def (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu0),
        .ram   (ram0)
    );

    pdp8_mem_seq #(
        .RD_CYCLES (1),
        .WR_SETUP  (1),
        .WR_PULSE  (1),
        .WR_HOLD   (1)
    ) u_dut_min (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu1),
        .ram   (ram1)
    );

    // Shared CPU-side drive; sel picks which sequencer sees req
    logic        sel = 1'b0;
    logic        req_d = 1'b0;
    logic        we_d = 1'b0;
    logic [14:0] addr_d = '0;
    logic [11:0] wdata_d = '0;

    assign cpu0.req   = req_d & ~sel;
    assign cpu1.req   = req_d & sel;
    assign cpu0.we    = we_d;
    assign cpu1.we    = we_d;
    assign cpu0.addr  = addr_d;
    assign cpu1.addr  = addr_d;
    assign cpu0.wdata = wdata_d;
    assign cpu1.wdata = wdata_d;

    logic        o_rd, o_wr, o_ack, o_busy;
    logic [14:0] o_addr;
    logic [11:0] o_din, o_rdata;
    assign o_rd    = sel ? ram1.ram_rd      : ram0.ram_rd;
    assign o_wr    = sel ? ram1.ram_wr      : ram0.ram_wr;
    assign o_ack   = sel ? cpu1.ack         : cpu0.ack;
    assign o_busy  = sel ? cpu1.busy        : cpu0.busy;
    assign o_addr  = sel ? ram1.ram_addr    : ram0.ram_addr;
    assign o_din   = sel ? ram1.ram_data_in : ram0.ram_data_in;
    assign o_rdata = sel ? cpu1.rdata       : cpu0.rdata;

    // 32Kx12 SRAM model: drives data only while output enable is high
    logic [11:0] mem [0:32767];
    logic        mem_init = 1'b0;
    assign ram0.ram_data_out = ram0.ram_rd ? mem[ram0.ram_addr] : 12'd0;
    assign ram1.ram_data_out = ram1.ram_rd ? mem[ram1.ram_addr] : 12'd0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 12'd0;
            mem[15'o17777] <= 12'o5252;
        end else if (o_wr) begin
            mem[o_addr] <= o_din;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int ack_total = 0;
    int ops_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Strobe exclusion on both sequencers, and a running ack tally
    always @(negedge clk) begin
        n_cmp++;
        if ((ram0.ram_rd && ram0.ram_wr) || (ram1.ram_rd && ram1.ram_wr)) begin
            n_bad++;
            $display("FAIL rd_wr_exclusive: got both strobes high expected at most one");
        end
        ack_total += int'(cpu0.ack) + int'(cpu1.ack);
    end

    int rd_c, su_c, pw_c, hd_c;

    task automatic set_sel(input logic s);
        sel  = s;
        rd_c = s ? 1 : 2;
        su_c = s ? 1 : 1;
        pw_c = s ? 1 : 2;
        hd_c = s ? 1 : 1;
    endtask

    task automatic idle(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({nm, " idle ack/busy"}, 32'({o_ack, o_busy}), 32'd0);
        end
    endtask

    // Issue one request now (caller is at a negedge with busy=0) and check every
    // cycle until the ack cycle; returns at the negedge of the ack cycle.
    task automatic do_op(input logic we, input logic [14:0] a, input logic [11:0] wd,
                         input logic [11:0] exp_rd, input logic inject, input string nm);
        int          total;
        logic [11:0] rdata_before;
        logic        e_rd, e_wr, e_ack, e_busy;
        total        = we ? (su_c + pw_c + hd_c + 1) : (rd_c + 1);
        rdata_before = o_rdata;
        req_d = 1'b1; we_d = we; addr_d = a; wdata_d = wd;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (inject) begin
                    req_d = 1'b1; we_d = 1'b1; addr_d = 15'o00001; wdata_d = 12'o7777;
                end else begin
                    req_d = 1'b0; we_d = ~we; addr_d = ~a; wdata_d = ~wd;
                end
            end else if (k == 2) begin
                req_d = 1'b0;
            end
            e_rd   = !we && (k <= rd_c);
            e_wr   = we && (k > su_c) && (k <= su_c + pw_c);
            e_ack  = (k == total);
            e_busy = (k < total);
            chk($sformatf("%s c%0d rd/wr/ack/busy", nm, k), 32'({o_rd, o_wr, o_ack, o_busy}),
                32'({e_rd, e_wr, e_ack, e_busy}));
            chk($sformatf("%s c%0d ram_addr", nm, k), 32'(o_addr), 32'(a));
            if (we) chk($sformatf("%s c%0d ram_data_in", nm, k), 32'(o_din), 32'(wd));
            if (k == total)
                chk({nm, " rdata"}, 32'(o_rdata), 32'(we ? rdata_before : exp_rd));
        end
        ops_exp++;
    endtask

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [11:0] wdata;
        logic [11:0] exp_rdata;
        logic        inject;
    } vec_t;

    vec_t        vecs [8];
    logic [11:0] ref_mem [0:63];

    initial begin
        vecs[0] = '{we: 1'b0, addr: 15'o17777, wdata: 12'o0000, exp_rdata: 12'o5252, inject: 1'b0};
        vecs[1] = '{we: 1'b1, addr: 15'o00200, wdata: 12'o7402, exp_rdata: 12'o0000, inject: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 15'o00200, wdata: 12'o0000, exp_rdata: 12'o7402, inject: 1'b0};
        vecs[3] = '{we: 1'b1, addr: 15'o00000, wdata: 12'o0001, exp_rdata: 12'o0000, inject: 1'b0};
        vecs[4] = '{we: 1'b0, addr: 15'o00000, wdata: 12'o0000, exp_rdata: 12'o0001, inject: 1'b1};
        vecs[5] = '{we: 1'b1, addr: 15'o17777, wdata: 12'o7777, exp_rdata: 12'o0000, inject: 1'b0};
        vecs[6] = '{we: 1'b0, addr: 15'o17777, wdata: 12'o0000, exp_rdata: 12'o7777, inject: 1'b0};
        vecs[7] = '{we: 1'b0, addr: 15'o12345, wdata: 12'o0000, exp_rdata: 12'o0000, inject: 1'b0};

        set_sel(1'b0);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset def outputs", 32'({ram0.ram_rd, ram0.ram_wr, cpu0.ack, cpu0.busy}), 32'd0);
        chk("reset def rdata/addr/din", 32'({cpu0.rdata, ram0.ram_addr, ram0.ram_data_in}), 32'd0);
        chk("reset min outputs", 32'({ram1.ram_rd, ram1.ram_wr, cpu1.ack, cpu1.busy}), 32'd0);
        chk("reset min rdata/addr/din", 32'({cpu1.rdata, ram1.ram_addr, ram1.ram_data_in}), 32'd0);
        reset = 1'b0;
        idle(2, "post reset");

        // Table runs back-to-back: each request is issued in the previous ack cycle
        for (int i = 0; i < 8; i++)
            do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].inject,
                  $sformatf("vec%0d", i));
        idle(2, "after table");

        // Reset during the first write-pulse cycle
        req_d = 1'b1; we_d = 1'b1; addr_d = 15'o00300; wdata_d = 12'o1111;
        @(negedge clk);
        req_d = 1'b0;
        @(negedge clk);
        chk("midreset pulse high", 32'(o_wr), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset strobes/ack/busy", 32'({o_rd, o_wr, o_ack, o_busy}), 32'd0);
        chk("midreset ram_addr", 32'(o_addr), 32'd0);
        reset = 1'b0;
        idle(3, "midreset no ack");
        do_op(1'b1, 15'o00400, 12'o4321, 12'o0000, 1'b0, "after reset wr");
        do_op(1'b0, 15'o00400, 12'o0000, 12'o4321, 1'b0, "after reset rd");
        idle(1, "after reset");

        // Minimum timing, random mixed traffic against a reference image
        set_sel(1'b1);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) ref_mem[i] = 12'd0;
        for (int i = 0; i < 1000; i++) begin
            logic        rw;
            logic [5:0]  ra;
            logic [11:0] rwd;
            rw  = 1'($urandom_range(0, 1));
            ra  = 6'($urandom_range(0, 63));
            rwd = 12'($urandom);
            do_op(rw, {9'd0, ra}, rwd, ref_mem[ra], 1'b0, $sformatf("rnd%0d", i));
            if (rw) ref_mem[ra] = rwd;
            if ($urandom_range(0, 3) == 0) idle(1, "rnd gap");
        end
        idle(2, "end");

        chk("ack count vs accepts", 32'(ack_total), 32'(ops_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
